ctl_flock: RTL and testbench

- Parametrised successor of the single-duck position controller.
- Runs NUM_DUCKS independent flight channels: launch, edge bounce with a bounce budget, escape at the top edge, hit freeze, fall to ground.
- Sits between the game-logic/RNG block (launch parameters, hit strobes) and the duck draw path (x, y, show and pose flags per channel).
- Positions advance once per new_frame pulse.

---
 rtl/ctl_flock_pkg.sv | 23 ++
 rtl/ctl_flock_ch.sv | 214 +++++++++++++++++++++
 rtl/ctl_flock.sv | 67 ++++++
 tb/tb_ctl_flock.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctl_flock_pkg.sv
// Shared types and default constants for the multi-channel duck flight controller.
package ctl_flock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      FLY,
      ESCAPE,
      HIT,
      FALL,
      DONE
   } ch_state_e;

   localparam int unsigned SCREEN_W_DEFAULT    = 1024;
   localparam int unsigned SCREEN_H_DEFAULT    = 768;
   localparam int unsigned V_SPD_DEFAULT       = 15;
   localparam int unsigned FALL_SPD_DEFAULT    = 8;
   localparam int unsigned HIT_PAUSE_DEFAULT   = 30;
   localparam int unsigned FLY_TIMEOUT_DEFAULT = 600;
   localparam int unsigned REFL_W              = 5;
   localparam int unsigned CNT_W               = 16;

endpackage

// File: rtl/ctl_flock_ch.sv
// One duck flight channel: launch, bounce, escape, hit freeze and fall.
module ctl_flock_ch
   import ctl_flock_pkg::*;
#(
   parameter int unsigned X_W         = 11,
   parameter int unsigned Y_W         = 11,
   parameter int unsigned SCREEN_W    = SCREEN_W_DEFAULT,
   parameter int unsigned SCREEN_H    = SCREEN_H_DEFAULT,
   parameter int unsigned SPD_W       = 5,
   parameter int unsigned DEF_V_SPD   = V_SPD_DEFAULT,
   parameter int unsigned FALL_SPD    = FALL_SPD_DEFAULT,
   parameter int unsigned HIT_PAUSE   = HIT_PAUSE_DEFAULT,
   parameter int unsigned FLY_TIMEOUT = FLY_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              new_frame,
   input  logic              launch,
   input  logic              hit,
   input  logic              direction,
   input  logic [REFL_W-1:0] reflections,
   input  logic [SPD_W-1:0]  v_spd,
   input  logic [SPD_W-1:0]  h_spd,
   input  logic [X_W-1:0]    start_x,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic              show,
   output logic              duck_hit,
   output logic              escaped,
   output logic              down,
   output logic              busy
);

   localparam logic signed [X_W:0] X_MAX_S   = (X_W+1)'(SCREEN_W - 1);
   localparam logic signed [Y_W:0] Y_MAX_S   = (Y_W+1)'(SCREEN_H);
   localparam logic [REFL_W-1:0]   BOUNCE_MAX = '1;

   ch_state_e          state_q, state_n;
   logic [X_W-1:0]     x_n;
   logic [Y_W-1:0]     y_n;
   logic               dx_q, dx_n;
   logic               dy_q, dy_n;
   logic [SPD_W-1:0]   h_q, h_n;
   logic [SPD_W-1:0]   v_q, v_n;
   logic [REFL_W-1:0]  refl_q, refl_n;
   logic [REFL_W-1:0]  bc_q, bc_n;
   logic [CNT_W-1:0]   fc_q, fc_n;
   logic               show_n, duck_hit_n, escaped_n, down_n, busy_n;
   logic signed [X_W:0] nx;
   logic signed [Y_W:0] ny;
   logic               flip;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x        <= '0;
         y        <= '0;
         dx_q     <= 1'b0;
         dy_q     <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
         refl_q   <= '0;
         bc_q     <= '0;
         fc_q     <= '0;
         show     <= 1'b0;
         duck_hit <= 1'b0;
         escaped  <= 1'b0;
         down     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_n;
         x        <= x_n;
         y        <= y_n;
         dx_q     <= dx_n;
         dy_q     <= dy_n;
         h_q      <= h_n;
         v_q      <= v_n;
         refl_q   <= refl_n;
         bc_q     <= bc_n;
         fc_q     <= fc_n;
         show     <= show_n;
         duck_hit <= duck_hit_n;
         escaped  <= escaped_n;
         down     <= down_n;
         busy     <= busy_n;
      end
   end

   // Next-state, motion and registered flag decode
   always_comb begin
      state_n   = state_q;
      x_n       = x;
      y_n       = y;
      dx_n      = dx_q;
      dy_n      = dy_q;
      h_n       = h_q;
      v_n       = v_q;
      refl_n    = refl_q;
      bc_n      = bc_q;
      fc_n      = fc_q;
      escaped_n = 1'b0;
      down_n    = 1'b0;
      flip      = 1'b0;

      nx = dx_q ? $signed((X_W+1)'(x)) + $signed((X_W+1)'(h_q))
                : $signed((X_W+1)'(x)) - $signed((X_W+1)'(h_q));
      ny = dy_q ? $signed((Y_W+1)'(y)) + $signed((Y_W+1)'(v_q))
                : $signed((Y_W+1)'(y)) - $signed((Y_W+1)'(v_q));

      case (state_q)
         IDLE: begin
            if (launch) state_n = LAUNCH;
         end
         LAUNCH: begin
            x_n     = (start_x > X_W'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : start_x;
            y_n     = Y_W'(SCREEN_H);
            h_n     = h_spd;
            v_n     = (v_spd == '0) ? SPD_W'(DEF_V_SPD) : v_spd;
            refl_n  = reflections;
            dx_n    = direction;
            dy_n    = 1'b0;
            fc_n    = '0;
            bc_n    = '0;
            state_n = FLY;
         end
         FLY: begin
            if (hit) begin
               state_n = HIT;
               fc_n    = '0;
            end else if (new_frame) begin
               fc_n = fc_q + CNT_W'(1);
               // Timeout preempts this frame's motion and any edge event
               if (fc_n >= CNT_W'(FLY_TIMEOUT)) begin
                  state_n = ESCAPE;
               end else begin
                  if (nx < 0) begin
                     x_n  = '0;
                     dx_n = ~dx_q;
                     flip = 1'b1;
                  end else if (nx > X_MAX_S) begin
                     x_n  = X_W'(SCREEN_W - 1);
                     dx_n = ~dx_q;
                     flip = 1'b1;
                  end else begin
                     x_n = X_W'(nx);
                  end
                  if (ny > Y_MAX_S) begin
                     y_n  = Y_W'(SCREEN_H);
                     dy_n = 1'b0;
                     flip = 1'b1;
                  end else if (ny < 0) begin
                     y_n = '0;
                     if (bc_q < refl_q) begin
                        dy_n = 1'b1;
                        flip = 1'b1;
                     end else begin
                        state_n = ESCAPE;
                     end
                  end else begin
                     y_n = Y_W'(ny);
                  end
                  if (flip && (bc_q != BOUNCE_MAX)) bc_n = bc_q + REFL_W'(1);
               end
            end
         end
         ESCAPE: begin
            if (hit) begin
               state_n = HIT;
               fc_n    = '0;
            end else if (new_frame) begin
               if (y <= Y_W'(v_q)) begin
                  y_n       = '0;
                  escaped_n = 1'b1;
                  state_n   = DONE;
               end else begin
                  y_n = y - Y_W'(v_q);
               end
            end
         end
         HIT: begin
            if (new_frame) begin
               fc_n = fc_q + CNT_W'(1);
               if (fc_n >= CNT_W'(HIT_PAUSE)) begin
                  fc_n    = '0;
                  state_n = FALL;
               end
            end
         end
         FALL: begin
            if (new_frame) begin
               if (((Y_W+1)'(y) + (Y_W+1)'(FALL_SPD)) >= (Y_W+1)'(SCREEN_H)) begin
                  y_n     = Y_W'(SCREEN_H);
                  down_n  = 1'b1;
                  state_n = DONE;
               end else begin
                  y_n = y + Y_W'(FALL_SPD);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      show_n     = (state_n == FLY) || (state_n == ESCAPE) || (state_n == HIT) || (state_n == FALL);
      duck_hit_n = (state_n == HIT) || (state_n == FALL);
      busy_n     = (state_n != IDLE);
   end

endmodule

// File: rtl/ctl_flock.sv
// Multi-channel duck position controller: one independent flight channel per duck.
module ctl_flock
   import ctl_flock_pkg::*;
#(
   parameter int unsigned NUM_DUCKS   = 2,
   parameter int unsigned X_W         = 11,
   parameter int unsigned Y_W         = 11,
   parameter int unsigned SCREEN_W    = SCREEN_W_DEFAULT,
   parameter int unsigned SCREEN_H    = SCREEN_H_DEFAULT,
   parameter int unsigned SPD_W       = 5,
   parameter int unsigned DEF_V_SPD   = V_SPD_DEFAULT,
   parameter int unsigned FALL_SPD    = FALL_SPD_DEFAULT,
   parameter int unsigned HIT_PAUSE   = HIT_PAUSE_DEFAULT,
   parameter int unsigned FLY_TIMEOUT = FLY_TIMEOUT_DEFAULT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          new_frame,
   input  logic [NUM_DUCKS-1:0]          launch,
   input  logic [NUM_DUCKS-1:0]          hit,
   input  logic [NUM_DUCKS-1:0]          duck_direction,
   input  logic [NUM_DUCKS*REFL_W-1:0]   reflections,
   input  logic [NUM_DUCKS*SPD_W-1:0]    duck_v_spd,
   input  logic [NUM_DUCKS*SPD_W-1:0]    duck_h_spd,
   input  logic [NUM_DUCKS*X_W-1:0]      duck_start_x,
   output logic [NUM_DUCKS*X_W-1:0]      duck_x,
   output logic [NUM_DUCKS*Y_W-1:0]      duck_y,
   output logic [NUM_DUCKS-1:0]          duck_show,
   output logic [NUM_DUCKS-1:0]          duck_hit,
   output logic [NUM_DUCKS-1:0]          duck_escaped,
   output logic [NUM_DUCKS-1:0]          duck_down,
   output logic [NUM_DUCKS-1:0]          busy
);

   for (genvar i = 0; i < NUM_DUCKS; i++) begin : g_ch
      ctl_flock_ch #(
         .X_W        (X_W),
         .Y_W        (Y_W),
         .SCREEN_W   (SCREEN_W),
         .SCREEN_H   (SCREEN_H),
         .SPD_W      (SPD_W),
         .DEF_V_SPD  (DEF_V_SPD),
         .FALL_SPD   (FALL_SPD),
         .HIT_PAUSE  (HIT_PAUSE),
         .FLY_TIMEOUT(FLY_TIMEOUT)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .new_frame  (new_frame),
         .launch     (launch[i]),
         .hit        (hit[i]),
         .direction  (duck_direction[i]),
         .reflections(reflections[i*REFL_W +: REFL_W]),
         .v_spd      (duck_v_spd[i*SPD_W +: SPD_W]),
         .h_spd      (duck_h_spd[i*SPD_W +: SPD_W]),
         .start_x    (duck_start_x[i*X_W +: X_W]),
         .x          (duck_x[i*X_W +: X_W]),
         .y          (duck_y[i*Y_W +: Y_W]),
         .show       (duck_show[i]),
         .duck_hit   (duck_hit[i]),
         .escaped    (duck_escaped[i]),
         .down       (duck_down[i]),
         .busy       (busy[i])
      );
   end

endmodule

// File: tb/tb_ctl_flock.sv
// Directed self-checking bench for ctl_flock: flight, bounce, escape, hit/fall, timeout, reset.
module tb_ctl_flock;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        new_frame;
   logic [1:0]  launch, hit, dir;
   logic [9:0]  refl, vspd, hspd;
   logic [21:0] sx;
   logic [21:0] dxo;
   logic [21:0] dyo;
   logic [1:0]  show, dhit, esc, dwn, busy;

   logic        t_launch, t_hit;
   logic [10:0] t_x, t_y;
   logic        t_show, t_dhit, t_esc, t_dwn, t_busy;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic        nf;
      logic        hit;
      logic [10:0] x;
      logic [10:0] y;
      logic        show;
      logic        dhit;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   ctl_flock u_dut (
      .clk(clk), .rst_n(rst_n), .new_frame(new_frame), .launch(launch), .hit(hit),
      .duck_direction(dir), .reflections(refl), .duck_v_spd(vspd), .duck_h_spd(hspd),
      .duck_start_x(sx), .duck_x(dxo), .duck_y(dyo), .duck_show(show), .duck_hit(dhit),
      .duck_escaped(esc), .duck_down(dwn), .busy(busy)
   );

   ctl_flock #(.NUM_DUCKS(1), .FLY_TIMEOUT(4)) u_to (
      .clk(clk), .rst_n(rst_n), .new_frame(new_frame), .launch(t_launch), .hit(t_hit),
      .duck_direction(1'b1), .reflections(5'd0), .duck_v_spd(5'd1), .duck_h_spd(5'd10),
      .duck_start_x(11'd100), .duck_x(t_x), .duck_y(t_y), .duck_show(t_show),
      .duck_hit(t_dhit), .duck_escaped(t_esc), .duck_down(t_dwn), .busy(t_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      tick();
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) frame();
   endtask

   task automatic set_ch(input int i, input logic [10:0] x0, input logic d,
                         input logic [4:0] h, input logic [4:0] v, input logic [4:0] r);
      sx[i*11 +: 11] = x0;
      dir[i]         = d;
      hspd[i*5 +: 5] = h;
      vspd[i*5 +: 5] = v;
      refl[i*5 +: 5] = r;
   endtask

   task automatic do_launch(input logic [1:0] m);
      launch = m;
      tick();
      launch = 2'b00;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   function automatic logic [10:0] gx(input int i);
      logic [21:0] v;
      v = dxo;
      return v[i*11 +: 11];
   endfunction

   function automatic logic [10:0] gy(input int i);
      logic [21:0] v;
      v = dyo;
      return v[i*11 +: 11];
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; new_frame = 1'b0; launch = '0; hit = '0; dir = '0;
      refl = '0; vspd = '0; hspd = '0; sx = '0; t_launch = 1'b0; t_hit = 1'b0;
      tbl[0] = '{1'b1, 1'b0, 11'd110, 11'd753, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 11'd120, 11'd738, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 11'd130, 11'd723, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 11'd130, 11'd723, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 11'd130, 11'd723, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 11'd130, 11'd723, 1'b1, 1'b1};
      repeat (3) tick();
      chk("rst_x", 32'(dxo), 0);
      chk("rst_y", 32'(dyo), 0);
      chk("rst_flags", 32'({show, dhit, esc, dwn, busy}), 0);
      chk("rst_to_flags", 32'({t_show, t_busy, t_x, t_y}), 0);
      rst_n = 1'b1;
      tick();

      // Launch and table-driven flight / hit rows on ch0
      set_ch(0, 11'd100, 1'b1, 5'd10, 5'd0, 5'd2);
      launch = 2'b01;
      tick();
      launch = 2'b00;
      chk("launch_busy", 32'(busy[0]), 1);
      chk("launch_show_pre", 32'(show[0]), 0);
      tick();
      chk("launch_x", 32'(gx(0)), 100);
      chk("launch_y", 32'(gy(0)), 768);
      chk("launch_show", 32'(show[0]), 1);
      for (int r = 0; r < 6; r++) begin
         new_frame = tbl[r].nf;
         hit[0]    = tbl[r].hit;
         tick();
         new_frame = 1'b0;
         hit       = '0;
         tick();
         chk($sformatf("tbl%0d_x", r), 32'(gx(0)), 32'(tbl[r].x));
         chk($sformatf("tbl%0d_y", r), 32'(gy(0)), 32'(tbl[r].y));
         chk($sformatf("tbl%0d_show", r), 32'(show[0]), 32'(tbl[r].show));
         chk($sformatf("tbl%0d_hit", r), 32'(dhit[0]), 32'(tbl[r].dhit));
      end
      do_reset();
      chk("reset_sync_busy", 32'(busy), 0);

      // Right-wall bounce on ch0, start_x clamp on ch1
      set_ch(0, 11'd1020, 1'b1, 5'd10, 5'd5, 5'd3);
      set_ch(1, 11'd2000, 1'b0, 5'd3, 5'd5, 5'd3);
      do_launch(2'b11);
      chk("wall_x0_l", 32'(gx(0)), 1020);
      chk("clamp_x1_l", 32'(gx(1)), 1023);
      frame();
      chk("wall_x0_f1", 32'(gx(0)), 1023);
      chk("wall_y0_f1", 32'(gy(0)), 763);
      chk("clamp_x1_f1", 32'(gx(1)), 1020);
      frame();
      chk("wall_x0_f2", 32'(gx(0)), 1013);
      chk("wall_y0_f2", 32'(gy(0)), 758);
      chk("clamp_x1_f2", 32'(gx(1)), 1017);
      do_reset();

      // Zero-budget escape at the top edge, zero horizontal speed
      set_ch(0, 11'd50, 1'b1, 5'd0, 5'd0, 5'd0);
      do_launch(2'b01);
      frames(51);
      chk("esc_y51", 32'(gy(0)), 3);
      chk("esc_x51", 32'(gx(0)), 50);
      frame();
      chk("esc_y52", 32'(gy(0)), 0);
      chk("esc_busy52", 32'({busy[0], show[0], esc[0]}), 32'(3'b110));
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      chk("esc_pulse", 32'(esc[0]), 1);
      chk("esc_done_show", 32'(show[0]), 0);
      chk("esc_done_busy", 32'(busy[0]), 1);
      tick();
      chk("esc_pulse_end", 32'(esc[0]), 0);
      chk("esc_idle_busy", 32'(busy[0]), 0);
      do_reset();

      // Two channels, opposite directions, hit on ch1 only
      set_ch(0, 11'd500, 1'b1, 5'd5, 5'd4, 5'd3);
      set_ch(1, 11'd500, 1'b0, 5'd5, 5'd4, 5'd3);
      do_launch(2'b11);
      frames(3);
      chk("two_x0_f3", 32'(gx(0)), 515);
      chk("two_x1_f3", 32'(gx(1)), 485);
      new_frame = 1'b1;
      hit = 2'b10;
      tick();
      new_frame = 1'b0;
      hit = 2'b00;
      tick();
      frames(3);
      chk("two_x0", 32'(gx(0)), 535);
      chk("two_y0", 32'(gy(0)), 740);
      chk("two_x1", 32'(gx(1)), 485);
      chk("two_y1", 32'(gy(1)), 756);
      chk("two_hit", 32'(dhit), 32'(2'b10));
      do_reset();

      // Hit coinciding with new_frame, pause, then fall to the ground
      set_ch(0, 11'd300, 1'b1, 5'd0, 5'd16, 5'd0);
      do_launch(2'b01);
      frames(23);
      chk("hf_y23", 32'(gy(0)), 400);
      new_frame = 1'b1;
      hit = 2'b01;
      tick();
      new_frame = 1'b0;
      hit = 2'b00;
      tick();
      chk("hf_x_hit", 32'(gx(0)), 300);
      chk("hf_y_hit", 32'(gy(0)), 400);
      chk("hf_dhit", 32'(dhit[0]), 1);
      frames(29);
      chk("hf_y_pause", 32'(gy(0)), 400);
      frame();
      chk("hf_y_fall0", 32'(gy(0)), 400);
      chk("hf_dhit_fall", 32'(dhit[0]), 1);
      frames(45);
      chk("hf_y_760", 32'(gy(0)), 760);
      chk("hf_down_pre", 32'(dwn[0]), 0);
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      chk("hf_down", 32'(dwn[0]), 1);
      chk("hf_y_gnd", 32'(gy(0)), 768);
      chk("hf_show_done", 32'(show[0]), 0);
      tick();
      chk("hf_down_end", 32'(dwn[0]), 0);
      chk("hf_idle", 32'(busy[0]), 0);

      // Async reset in the middle of a fall
      do_launch(2'b01);
      frames(23);
      new_frame = 1'b1;
      hit = 2'b01;
      tick();
      new_frame = 1'b0;
      hit = 2'b00;
      tick();
      frames(35);
      chk("ar_y_fall", 32'(gy(0)), 440);
      rst_n = 1'b0;
      #1;
      chk("ar_x", 32'(dxo), 0);
      chk("ar_y", 32'(dyo), 0);
      chk("ar_flags", 32'({show, dhit, esc, dwn, busy}), 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         new_frame = k[0];
         tick();
         chk("ar_no_down", 32'({dwn, busy}), 0);
      end
      new_frame = 1'b0;

      // Fly timeout forces escape on frame 4
      t_launch = 1'b1;
      tick();
      t_launch = 1'b0;
      tick();
      frames(3);
      chk("to_x3", 32'(t_x), 130);
      chk("to_y3", 32'(t_y), 765);
      frame();
      chk("to_x4", 32'(t_x), 130);
      chk("to_y4", 32'(t_y), 765);
      frame();
      chk("to_x5", 32'(t_x), 130);
      chk("to_y5", 32'(t_y), 764);
      chk("to_show", 32'({t_show, t_dhit}), 32'(2'b10));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
